// File: rtl/alien_missile_ctrl.sv
// Enemy bomb controller: launches from the attacking alien, falls one step per frame,
// and reports ship collisions with a level/ack handshake. Optional macro AMISSILE_AIM_EN homes X toward the ship.
module alien_missile_ctrl #(
    parameter int STEP_Y      = 4,
    parameter int LAUNCH_OFFS = 8,
    parameter int FLOOR_Y     = 479,
    parameter int COOLDOWN    = 30,
    parameter int HIT_DX      = 9,
    parameter int HIT_DY      = 11
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       enable,
    input  logic       fire_req,
    input  logic [9:0] ALIEN_X,
    input  logic [9:0] ALIEN_Y,
    input  logic [9:0] SHIPX,
    input  logic [9:0] SHIPY,
    input  logic       ship_hit_ack,
    output logic [9:0] AMISSILE_X,
    output logic [9:0] AMISSILE_Y,
    output logic       amissile_on,
    output logic       fire_ack,
    output logic       ship_hit
);

    typedef enum logic [1:0] {IDLE, FLY, HIT, COOL} state_t;

    // COOLDOWN of 0 behaves like 1, so the load value never underflows.
    localparam int CNT_W = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (COOLDOWN > 1) ? CNT_W'(COOLDOWN - 1) : '0;

    state_t           state_q, state_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             on_q, on_d;
    logic             fire_ack_q, fire_ack_d;
    logic             ship_hit_q, ship_hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [10:0] launch_y;
    logic [10:0] next_y;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic        collide;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            on_q       <= 1'b0;
            fire_ack_q <= 1'b0;
            ship_hit_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            on_q       <= on_d;
            fire_ack_q <= fire_ack_d;
            ship_hit_q <= ship_hit_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        launch_y   = {1'b0, ALIEN_Y} + 11'(LAUNCH_OFFS);
        next_y     = {1'b0, y_q} + 11'(STEP_Y);
        dx         = (x_q >= SHIPX) ? (x_q - SHIPX) : (SHIPX - x_q);
        dy         = (y_q >= SHIPY) ? (y_q - SHIPY) : (SHIPY - y_q);
        collide    = (dx <= 10'(HIT_DX)) && (dy <= 10'(HIT_DY));

        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        on_d       = on_q;
        fire_ack_d = 1'b0;
        ship_hit_d = ship_hit_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (enable && fire_req && (launch_y <= 11'(FLOOR_Y))) begin
                    state_d    = FLY;
                    x_d        = ALIEN_X;
                    y_d        = launch_y[9:0];
                    on_d       = 1'b1;
                    fire_ack_d = 1'b1;
                end
            end
            FLY: begin
                // Collision is tested on the current position before moving.
                if (!enable) begin
                    state_d = IDLE;
                    on_d    = 1'b0;
                end else if (collide) begin
                    state_d    = HIT;
                    on_d       = 1'b0;
                    ship_hit_d = 1'b1;
                end else if (next_y > 11'(FLOOR_Y)) begin
                    state_d = COOL;
                    on_d    = 1'b0;
                    cnt_d   = CNT_LOAD;
                end else begin
                    y_d = next_y[9:0];
`ifdef AMISSILE_AIM_EN
                    if (x_q < SHIPX) begin
                        x_d = x_q + 10'd1;
                    end else if (x_q > SHIPX) begin
                        x_d = x_q - 10'd1;
                    end
`else
                    x_d = x_q;
`endif
                end
            end
            HIT: begin
                if (ship_hit_ack) begin
                    state_d    = COOL;
                    ship_hit_d = 1'b0;
                    cnt_d      = CNT_LOAD;
                end
            end
            COOL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign AMISSILE_X  = x_q;
    assign AMISSILE_Y  = y_q;
    assign amissile_on = on_q;
    assign fire_ack    = fire_ack_q;
    assign ship_hit    = ship_hit_q;

endmodule
